// File: rtl/instr_encoder_pkg.sv
// Shared types for the instruction encoder: opcode/funct aliases, formats and FSM states.
// The HALT word is what the loader appends after the last user instruction.
package instr_encoder_pkg;

    typedef logic [5:0]  opcode_t;
    typedef logic [5:0]  funct_t;
    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    localparam opcode_t RTYPE = 6'h00;
    localparam opcode_t HALT  = 6'h3F;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2
    } enc_fmt_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        HALT_WR = 2'd2,
        DONE    = 2'd3
    } encst_t;

    localparam word_t HALT_WORD = {HALT, 26'b0};

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: instruction fields plus format select -> 32-bit MIPS word.
// legal drops low for the reserved format code 3.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] jaddr,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (fmt)
            FMT_R:   word = {RTYPE, rs, rt, rd, shamt, funct};
            FMT_I:   word = {opcode, rs, rt, imm};
            FMT_J:   word = {opcode, jaddr};
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs handshaked instruction fields and writes them to instruction
// memory through a wait-stalled port, then appends a HALT word and stops.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_fmt,
    input  logic [5:0]  req_opcode,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_shamt,
    input  logic [5:0]  req_funct,
    input  logic [15:0] req_imm,
    input  logic [25:0] req_jaddr,
    input  logic        req_last,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_store,
    input  logic        mem_wait,
    output logic        done,
    output logic        overflow,
    output logic        bad_fmt,
    output logic [10:0] word_cnt
);

    // A single-word image has no room for user words: the first one always overflows.
    localparam bit          SINGLE = (MAX_WORDS <= 1);
    localparam logic [10:0] CAP    = 11'(MAX_WORDS - 1);

    encst_t      state_q, state_d;
    logic [31:0] store_q, store_d;
    logic        last_q, last_d;
    logic [31:0] addr_q, addr_d;
    logic [10:0] cnt_q, cnt_d;
    logic        overflow_q, overflow_d;
    logic        bad_fmt_q, bad_fmt_d;

    logic [31:0] packed_word;
    logic        packed_legal;
    logic        write_done;
    logic        cap_hit;
    logic        go_halt;

    instr_pack u_pack (
        .fmt    (req_fmt),
        .opcode (req_opcode),
        .rs     (req_rs),
        .rt     (req_rt),
        .rd     (req_rd),
        .shamt  (req_shamt),
        .funct  (req_funct),
        .imm    (req_imm),
        .jaddr  (req_jaddr),
        .word   (packed_word),
        .legal  (packed_legal)
    );

    assign write_done = !mem_wait;
    assign cap_hit    = (cnt_q + 11'd1) == CAP;
    assign go_halt    = SINGLE || last_q || cap_hit;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= IDLE;
            store_q    <= '0;
            last_q     <= 1'b0;
            addr_q     <= BASE_ADDR;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            bad_fmt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            bad_fmt_q  <= bad_fmt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid && packed_legal) state_d = WRITE;
            end
            WRITE: begin
                if (write_done) state_d = go_halt ? HALT_WR : IDLE;
            end
            HALT_WR: begin
                if (write_done) state_d = DONE;
            end
            default: state_d = DONE;
        endcase
    end

    // Word, address and count registers follow the same handshake points as the FSM.
    always_comb begin
        store_d    = store_q;
        last_d     = last_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        bad_fmt_d  = bad_fmt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (packed_legal) begin
                        store_d = packed_word;
                        last_d  = req_last;
                    end else begin
                        bad_fmt_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (write_done) begin
                    addr_d = addr_q + 32'd4;
                    cnt_d  = cnt_q + 11'd1;
                    if (SINGLE || (!last_q && cap_hit)) overflow_d = 1'b1;
                    if (go_halt) store_d = HALT_WORD;
                end
            end
            HALT_WR: begin
                if (write_done) cnt_d = cnt_q + 11'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        mem_wen   = (state_q == WRITE) || (state_q == HALT_WR);
        done      = (state_q == DONE);
        mem_addr  = addr_q;
        mem_store = store_q;
        overflow  = overflow_q;
        bad_fmt   = bad_fmt_q;
        word_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a transaction-level model of expected memory writes and
// status, checked every cycle, plus directed cases with literal expected words.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam int          MAXW = 4;
    localparam logic [31:0] HALTW = 32'hFC00_0000;

    logic        CLK, nRST;
    logic        req_valid, req_ready, req_last;
    logic [1:0]  req_fmt;
    logic [5:0]  req_opcode, req_funct;
    logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
    logic [15:0] req_imm;
    logic [25:0] req_jaddr;
    logic        mem_wen, mem_wait, done, overflow, bad_fmt;
    logic [31:0] mem_addr, mem_store;
    logic [10:0] word_cnt;

    instr_encoder #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt(req_fmt), .req_opcode(req_opcode),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_shamt(req_shamt), .req_funct(req_funct),
        .req_imm(req_imm), .req_jaddr(req_jaddr), .req_last(req_last),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_store(mem_store),
        .mem_wait(mem_wait), .done(done), .overflow(overflow),
        .bad_fmt(bad_fmt), .word_cnt(word_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference packing straight from the field layout, using shifts and masks.
    function automatic logic [31:0] encode(input int fmt, input int op, input int rs, input int rt,
                                           input int rd, input int sh, input int fn,
                                           input int imm, input int ja);
        int w;
        w = 0;
        if (fmt == 0)      w = ((rs & 31) << 21) | ((rt & 31) << 16) | ((rd & 31) << 11) | ((sh & 31) << 6) | (fn & 63);
        else if (fmt == 1) w = ((op & 63) << 26) | ((rs & 31) << 21) | ((rt & 31) << 16) | (imm & 65535);
        else if (fmt == 2) w = ((op & 63) << 26) | (ja & 32'h03FF_FFFF);
        return 32'(w);
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          halt;
        bit          ovf;
    } wr_t;

    wr_t         exp_q[$];
    int          sched, completed, cycle;
    bit          exp_done, exp_ovf, exp_bad, halt_sched, fresh, model_on;
    int          acc_cycle[$];
    logic [31:0] wr_mem [0:15];
    bit          wait_rand;

    initial begin
        model_on = 0;
        cycle    = 0;
    end

    always @(negedge CLK) begin
        bit  exp_ready;
        wr_t e;
        logic [31:0] w;
        cycle++;
        exp_ready = (exp_q.size() == 0) && !halt_sched;
        if (model_on) begin
            checkOutput("req_ready", req_ready, exp_ready);
            checkOutput("mem_wen", mem_wen, exp_q.size() != 0);
            checkOutput("word_cnt", word_cnt, completed);
            checkOutput("done", done, exp_done);
            checkOutput("overflow", overflow, exp_ovf);
            checkOutput("bad_fmt", bad_fmt, exp_bad);
            if (exp_q.size() != 0) begin
                checkOutput("mem_addr", mem_addr, exp_q[0].addr);
                checkOutput("mem_store", mem_store, exp_q[0].data);
            end else begin
                checkOutput("idle_addr", mem_addr, BASE + 32'(4 * sched));
            end
            if (fresh) checkOutput("reset_store", mem_store, 32'h0);
        end
        if (nRST && mem_wen && !mem_wait)
            wr_mem[4'((mem_addr - BASE) >> 2)] = mem_store;
        if (!nRST) begin
            exp_q.delete();
            sched = 0; completed = 0;
            exp_done = 0; exp_ovf = 0; exp_bad = 0; halt_sched = 0;
            fresh = 1; model_on = 1;
            for (int i = 0; i < 16; i++) wr_mem[i] = '0;
        end else if (model_on) begin
            if (exp_q.size() != 0 && !mem_wait) begin
                e = exp_q.pop_front();
                completed++;
                if (e.halt) exp_done = 1;
                if (e.ovf)  exp_ovf  = 1;
            end else if (exp_ready && req_valid) begin
                acc_cycle.push_back(cycle);
                if (req_fmt == 2'd3) begin
                    exp_bad = 1;
                end else begin
                    w = encode(int'(req_fmt), int'(req_opcode), int'(req_rs), int'(req_rt), int'(req_rd),
                               int'(req_shamt), int'(req_funct), int'(req_imm), int'(req_jaddr));
                    fresh = 0;
                    e.addr = BASE + 32'(4 * sched);
                    e.data = w;
                    e.halt = 0;
                    sched++;
                    e.ovf  = !req_last && (sched == MAXW - 1);
                    exp_q.push_back(e);
                    if (req_last || e.ovf) begin
                        e.addr = BASE + 32'(4 * sched);
                        e.data = HALTW;
                        e.halt = 1;
                        e.ovf  = 0;
                        exp_q.push_back(e);
                        halt_sched = 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        if (wait_rand) mem_wait = ($urandom_range(0, 2) == 0);
    endtask

    task automatic doReset();
        tick();
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
    endtask

    task automatic applyStimulus(input int fmt, input int op, input int rs, input int rt, input int rd,
                                 input int sh, input int fn, input int imm, input int ja,
                                 input bit last, output bit acked);
        req_fmt    = 2'(fmt);
        req_opcode = 6'(op);
        req_rs     = 5'(rs);
        req_rt     = 5'(rt);
        req_rd     = 5'(rd);
        req_shamt  = 5'(sh);
        req_funct  = 6'(fn);
        req_imm    = 16'(imm);
        req_jaddr  = 26'(ja);
        req_last   = last;
        req_valid  = 1'b1;
        acked      = 0;
        for (int i = 0; i < 40 && !acked; i++) begin
            @(negedge CLK);
            if (req_ready) acked = 1;
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        bit got;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge CLK);
            got = done;
            if (!got) tick();
        end
        checkOutput("done_wait", got, 1);
    endtask

    initial begin
        bit ack;
        int acks, nreq, fmt;
        nRST = 1'b0; req_valid = 1'b0; req_last = 1'b0; req_fmt = '0; req_opcode = '0;
        req_rs = '0; req_rt = '0; req_rd = '0; req_shamt = '0; req_funct = '0;
        req_imm = '0; req_jaddr = '0; mem_wait = 1'b0; wait_rand = 0;

        checkOutput("model_R", encode(0, 0, 1, 2, 3, 0, 'h20, 0, 0), 32'h0022_1820);
        checkOutput("model_I", encode(1, 'h09, 0, 5, 0, 0, 0, 'hFFFF, 0), 32'h2405_FFFF);
        checkOutput("model_J", encode(2, 'h02, 0, 0, 0, 0, 0, 0, 'h10), 32'h0800_0010);

        // Reset state and a single R word followed by HALT.
        doReset();
        @(negedge CLK);
        checkOutput("rst_ready", req_ready, 1);
        checkOutput("rst_wen", mem_wen, 0);
        checkOutput("rst_addr", mem_addr, BASE);
        checkOutput("rst_cnt", word_cnt, 0);
        tick();
        applyStimulus(0, 0, 1, 2, 3, 0, 'h20, 0, 0, 1, ack);
        waitDone(20);
        checkOutput("t1_word0", wr_mem[0], 32'h0022_1820);
        checkOutput("t1_halt", wr_mem[1], HALTW);
        checkOutput("t1_cnt", word_cnt, 2);

        // I word under a three-cycle stall.
        doReset();
        mem_wait = 1'b1;
        applyStimulus(1, 'h09, 0, 5, 0, 0, 0, 'hFFFF, 0, 1, ack);
        tick(); tick(); tick();
        mem_wait = 1'b0;
        @(negedge CLK);
        checkOutput("t2_wen_stall", mem_wen, 1);
        checkOutput("t2_cnt_stall", word_cnt, 0);
        tick();
        @(negedge CLK);
        checkOutput("t2_cnt_after", word_cnt, 1);
        checkOutput("t2_word", wr_mem[0], 32'h2405_FFFF);
        tick();

        // Back-to-back J words: second accepted two cycles after the first.
        doReset();
        acc_cycle.delete();
        applyStimulus(2, 'h02, 0, 0, 0, 0, 0, 0, 'h10, 0, ack);
        applyStimulus(2, 'h02, 0, 0, 0, 0, 0, 0, 'h20, 1, ack);
        waitDone(20);
        checkOutput("t3_gap", (acc_cycle.size() >= 2) ? 32'(acc_cycle[1] - acc_cycle[0]) : 32'hFFFF_FFFF, 2);
        checkOutput("t3_word", wr_mem[0], 32'h0800_0010);

        // Capacity overflow: five non-last requests, only three fit.
        doReset();
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 'h08, k, k + 1, 0, 0, 0, k * 7, 0, 0, ack);
            acks += int'(ack);
        end
        @(negedge CLK);
        checkOutput("t4_acks", acks, 3);
        checkOutput("t4_done", done, 1);
        checkOutput("t4_ovf", overflow, 1);
        checkOutput("t4_cnt", word_cnt, 4);
        checkOutput("t4_halt", wr_mem[3], HALTW);

        // Illegal format is dropped, next legal word lands at the base.
        doReset();
        applyStimulus(3, 'h08, 1, 1, 1, 1, 1, 1, 1, 0, ack);
        @(negedge CLK);
        checkOutput("t5_bad", bad_fmt, 1);
        checkOutput("t5_cnt", word_cnt, 0);
        checkOutput("t5_wen", mem_wen, 0);
        tick();
        applyStimulus(1, 'h0D, 3, 4, 0, 0, 0, 'h1234, 0, 1, ack);
        waitDone(20);
        checkOutput("t5_word", wr_mem[0], encode(1, 'h0D, 3, 4, 0, 0, 0, 'h1234, 0));

        // Reset in the middle of a stalled write.
        doReset();
        mem_wait = 1'b1;
        applyStimulus(0, 0, 7, 8, 9, 1, 'h22, 0, 0, 0, ack);
        tick();
        nRST = 1'b0;
        tick();
        @(negedge CLK);
        checkOutput("t6_wen", mem_wen, 0);
        checkOutput("t6_addr", mem_addr, BASE);
        checkOutput("t6_cnt", word_cnt, 0);
        checkOutput("t6_ready", req_ready, 1);
        mem_wait = 1'b0;
        tick();
        nRST = 1'b1;

        // Random images with random stalls, checked by the model every cycle.
        wait_rand = 1;
        for (int img = 0; img < 40; img++) begin
            doReset();
            nreq = $urandom_range(1, 6);
            for (int k = 0; k < nreq; k++) begin
                fmt = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
                applyStimulus(fmt, $urandom_range(0, 63), $urandom_range(0, 31), $urandom_range(0, 31),
                              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
                              $urandom_range(0, 65535), $urandom_range(0, 32'h03FF_FFFF),
                              (k == nreq - 1) && ($urandom_range(0, 1) == 1), ack);
                if (!ack) break;
                for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            end
            for (int g = $urandom_range(0, 12); g > 0; g--) tick();
        end
        wait_rand = 0;
        mem_wait  = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
